// File: rtl/reset_release_sequencer.sv
// Purpose : holds CHANNELS reset domains until PLL lock is stable, then releases them in index order; free-running heartbeat.
// Latency : Locked -> lock_s 2 cycles; first release LOCK_FILTER+HOLD_CYCLES cycles after lock_s rises; STAGE_GAP between channels.
// Backpressure: none; Restart and lock loss abort immediately and re-arm the sequence.
//
// Ports:
//   Clock, Reset        sole clock, synchronous active-high reset
//   Locked              PLL lock, asynchronous (synchronised here)
//   Restart             synchronous soft-restart pulse
//   ChannelReset        per-domain reset, active-high, registered
//   Running             high once every channel is released
//   LockLossCount       saturating count of lock losses after filtering
//   Leds, Alive         heartbeat taps
module reset_release_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 63,
    parameter int STAGE_GAP   = 16,
    parameter int LOCK_FILTER = 8,
    parameter int HB_WIDTH    = 32,
    parameter int LED_WIDTH   = 4,
    parameter int LED_LSB     = 21
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Locked,
    input  logic                 Restart,
    output logic [CHANNELS-1:0]  ChannelReset,
    output logic                 Running,
    output logic [7:0]           LockLossCount,
    output logic [LED_WIDTH-1:0] Leds,
    output logic                 Alive
);

    localparam int CYC_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int FW      = $clog2(LOCK_FILTER + 1);
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam int IW      = $clog2(CHANNELS + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(CHANNELS - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, STAGE, RUN} state_t;

    state_t                state, state_n;
    logic                  sync1, lock_s;
    logic [FW-1:0]         filt_cnt, filt_n;
    logic [CW-1:0]         cyc_cnt, cyc_n;
    logic [IW-1:0]         idx, idx_n;
    logic [CHANNELS-1:0]   cr_n;
    logic                  run_n;
    logic [7:0]            llc_n;
    logic [HB_WIDTH-1:0]   hb;
    logic                  abort;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1         <= 1'b0;
            lock_s        <= 1'b0;
            state         <= WAIT_LOCK;
            filt_cnt      <= '0;
            cyc_cnt       <= '0;
            idx           <= '0;
            ChannelReset  <= '1;
            Running       <= 1'b0;
            LockLossCount <= '0;
            hb            <= '0;
        end else begin
            sync1         <= Locked;
            lock_s        <= sync1;
            state         <= state_n;
            filt_cnt      <= filt_n;
            cyc_cnt       <= cyc_n;
            idx           <= idx_n;
            ChannelReset  <= cr_n;
            Running       <= run_n;
            LockLossCount <= llc_n;
            hb            <= hb + 1'b1;
        end
    end

    // Any lock drop or restart outside WAIT_LOCK tears the whole sequence down.
    assign abort = (state != WAIT_LOCK) && (!lock_s || Restart);

    always_comb begin
        state_n = state;
        filt_n  = filt_cnt;
        cyc_n   = cyc_cnt;
        idx_n   = idx;
        cr_n    = ChannelReset;
        run_n   = Running;
        llc_n   = LockLossCount;

        if (abort) begin
            state_n = WAIT_LOCK;
            filt_n  = '0;
            cyc_n   = '0;
            idx_n   = '0;
            cr_n    = '1;
            run_n   = 1'b0;
            // Only genuine lock loss is counted; a soft restart is not a fault.
            if (!lock_s && LockLossCount != 8'hFF) begin
                llc_n = LockLossCount + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (Restart || !lock_s) begin
                        filt_n = '0;
                    end else if (filt_cnt == FILT_LAST) begin
                        filt_n  = '0;
                        cyc_n   = '0;
                        state_n = HOLD;
                    end else begin
                        filt_n = filt_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cyc_cnt == HOLD_LAST) begin
                        cr_n[0] = 1'b0;
                        cyc_n   = '0;
                        if (CHANNELS == 1) begin
                            state_n = RUN;
                            run_n   = 1'b1;
                        end else begin
                            state_n = STAGE;
                            idx_n   = IW'(1);
                        end
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
                STAGE: begin
                    if (cyc_cnt == GAP_LAST) begin
                        // Loop compare keeps the index width independent of the bus width.
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (IW'(i) == idx) begin
                                cr_n[i] = 1'b0;
                            end
                        end
                        cyc_n = '0;
                        idx_n = idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state_n = RUN;
                            run_n   = 1'b1;
                        end
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    // RUN: hold until abort.
                end
            endcase
        end
    end

    assign Leds  = hb[LED_LSB +: LED_WIDTH];
    assign Alive = hb[LED_LSB-1];

endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Parametrised reset-release and heartbeat block for FPGA top levels. It holds N downstream reset domains in reset until the PLL lock is stable and a hold time has elapsed, then releases the domains one by one in a fixed order. It re-arms automatically on loss of lock or on a soft restart request. It also provides the free-running heartbeat counter that drives board LEDs and the ALIVE pin. It sits between the clock generator and the generated `*_TopLevel` instances, all of which run on the same clock.

## Interface
Parameters:
- CHANNELS, 4: number of reset domains released in order; must be ≥1.
- HOLD_CYCLES, 63: cycles between stable lock and release of channel 0; must be ≥1.
- STAGE_GAP, 16: cycles between releases of consecutive channels; must be ≥1.
- LOCK_FILTER, 8: consecutive synchronised-high Locked samples required; must be ≥1.
- HB_WIDTH, 32: heartbeat counter width.
- LED_WIDTH, 4: Leds width.
- LED_LSB, 21: lowest heartbeat bit shown on Leds. LED_LSB ≥1 and LED_LSB+LED_WIDTH ≤ HB_WIDTH.

Ports:
- Clock  in  1  sole clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high.
- Locked  in  1  PLL lock; asynchronous to Clock.
- Restart  in  1  synchronous soft-restart pulse, active-high.
- ChannelReset  out  CHANNELS  per-domain reset, active-high, registered.
- Running  out  1  high once all channels are released.
- LockLossCount  out  8  saturating count of lock losses seen outside WAIT_LOCK.
- Leds  out  LED_WIDTH  heartbeat[LED_LSB+LED_WIDTH-1:LED_LSB].
- Alive  out  1  heartbeat[LED_LSB-1].

## Operation
- Locked passes through a 2-flop synchroniser to give lock_s. Restart is not synchronised.
- The block has four states: WAIT_LOCK, HOLD, STAGE and RUN.
- WAIT_LOCK:
  - The filter counter increments while lock_s=1 and clears when lock_s=0.
  - On the LOCK_FILTER-th consecutive high sample, go to HOLD and clear the cycle counter.
- HOLD:
  - The cycle counter runs for HOLD_CYCLES cycles.
  - On the final cycle, deassert ChannelReset[0]. If CHANNELS=1, go to RUN; otherwise go to STAGE with the channel index at 1.
- STAGE:
  - Every STAGE_GAP cycles, deassert ChannelReset[index] and increment the index.
  - When the last channel is released, go to RUN.
- RUN: hold.
- Abort condition: lock_s=0 or Restart=1 while in HOLD, STAGE or RUN. At that edge:
  - ChannelReset goes to all-ones and Running to 0.
  - All counters clear and the state returns to WAIT_LOCK.
  - LockLossCount increments (saturating at 255) only when lock_s=0. Restart alone does not count.
- Restart while in WAIT_LOCK clears the filter counter.
- Channels are released strictly in index order. A released channel never re-asserts reset except through an abort or Reset.
- Heartbeat:
  - Free-running counter that wraps modulo 2^HB_WIDTH.
  - Cleared only by Reset. Lock loss and Restart do not affect it.
- Counter widths are $clog2-sized from their parameters. No counter may wrap inside a state.

## Timing
- Values after a Reset edge:
  - ChannelReset is all-ones, Running=0, LockLossCount=0, heartbeat=0 (so Leds=0, Alive=0).
  - State is WAIT_LOCK and both synchroniser flops are 0.
- Reset takes precedence over Restart and Locked on the same edge.
- Release timing:
  - If Locked is first sampled high at edge 1 and stays high, HOLD is entered at edge E = 2+LOCK_FILTER.
  - ChannelReset[i] falls at edge E+HOLD_CYCLES+i·STAGE_GAP.
  - Running rises on the same edge as the last channel release.
- Lock-loss latency: if Locked is first sampled low at edge n, then after edge n+2 ChannelReset is all-ones and Running=0.
- Restart latency: Restart high at edge n gives all-ones/Running=0 after edge n.
- A lock glitch shorter than LOCK_FILTER samples during WAIT_LOCK restarts filtering.
- A single-cycle low of lock_s during HOLD, STAGE or RUN is a full abort.
- Heartbeat increments every cycle, including the cycle Reset deasserts.

## Test plan
- Ordered release:
  - Setup: CHANNELS=3, LOCK_FILTER=4, HOLD_CYCLES=8, STAGE_GAP=2; Reset low, then Locked high from edge 1.
  - Required: ChannelReset falls bit0@14, bit1@16, bit2@18; Running=1 @18; LockLossCount=0.
- Lock glitch during filtering:
  - Stimulus: Locked high, then low for one sample at edge 4, then high.
  - Required: HOLD entry delayed to edge 2+4+4=10 after re-rise alignment; ChannelReset remains 3'b111 until the computed edges.
- Lock loss in RUN:
  - Stimulus: drop Locked at edge 30.
  - Required: ChannelReset=3'b111 and Running=0 after edge 32; LockLossCount=1; re-lock repeats the release pattern with identical spacing.
- Restart mid-STAGE:
  - Stimulus: pulse Restart at edge 15.
  - Required: after edge 15, ChannelReset=3'b111 and LockLossCount unchanged.
- Saturation and wrap:
  - Stimulus: 300 lock losses.
  - Required: LockLossCount=255.
  - Setup: HB_WIDTH=8, LED_LSB=4, LED_WIDTH=4.
  - Required: Leds increments every 16 cycles, Alive toggles every 8 cycles, and the counter wraps at 256.
- Reset mid-operation:
  - Stimulus: Reset high during STAGE with Restart high.
  - Required: all outputs return to their reset values and the heartbeat is 0.
